// File: rtl/cei_addr_decoder_rt.sv
// Runtime-programmable OBI address decoder with in-order outstanding tracking and lockable rule table.
// Optional decode-miss counter enabled by defining ADDR_DEC_ERR_CNT_EN.
module cei_addr_decoder_rt #(
    parameter int NUM_RULES       = 6,
    parameter int NUM_SLAVES      = 6,
    parameter int MAX_OUTSTANDING = 4,
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    localparam int IW = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1),
    localparam int RW = SW + 64,
    // Entry k occupies bits [k*RW +: RW] as {idx, start_addr, end_addr}; end is exclusive
    parameter logic [NUM_RULES*RW-1:0] DEFAULT_RULES = {
        3'd5, 32'hF010_0000, 32'hF020_0000,
        3'd0, 32'h0000_0000, 32'h1000_0000,
        3'd2, 32'h4000_0000, 32'h8000_0000,
        3'd4, 32'hF000_0000, 32'hF001_0000,
        3'd1, 32'hF002_0000, 32'hF003_0000,
        3'd3, 32'hF010_0000, 32'hF010_8000
    }
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cfg_we_i,
    input  logic [IW-1:0] cfg_idx_i,
    input  logic [RW-1:0] cfg_rule_i,
    input  logic          cfg_valid_i,
    input  logic          cfg_lock_i,
    output logic          cfg_ready_o,
    output logic          cfg_locked_o,
    input  logic          m_req_i,
    input  logic [31:0]   m_addr_i,
    output logic          m_gnt_o,
    output logic          m_rvalid_o,
    output logic          m_err_o,
    output logic          s_req_o,
    output logic [SW-1:0] s_idx_o,
    input  logic          s_gnt_i,
    input  logic          s_rvalid_i,
    output logic [CW-1:0] outstanding_o,
    output logic          proto_err_o,
    output logic [15:0]   err_cnt_o
);

    logic [SW-1:0]        rule_idx   [NUM_RULES];
    logic [31:0]          rule_start [NUM_RULES];
    logic [31:0]          rule_end   [NUM_RULES];
    logic [NUM_RULES-1:0] rule_valid;
    logic [NUM_RULES-1:0] match;

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [SW-1:0] last_idx_reg;
    logic          err_pend_reg;
    logic          locked_reg;
    logic          proto_err_reg;

    logic          hit;
    logic [SW-1:0] dec_idx;
    logic          stall;
    logic          fwd_req;
    logic          miss_gnt;
    logic          accept;
    logic          rsp_dec;
    logic          cfg_ready;
    logic          wr_en;

    generate
        for (genvar gi = 0; gi < NUM_RULES; gi++) begin : g_match
            assign match[gi] = rule_valid[gi]
                             & (m_addr_i >= rule_start[gi])
                             & (m_addr_i <  rule_end[gi]);
        end
    endgenerate

    // Walk from the top so the lowest matching entry is the last one to assign.
    always_comb begin
        hit     = 1'b0;
        dec_idx = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                dec_idx = rule_idx[i];
            end
        end
    end

    // Responses stay in order only while every in-flight request targets the same slave.
    assign stall = (cnt_reg == CW'(MAX_OUTSTANDING))
                 | err_pend_reg
                 | ((cnt_reg != '0) & (!hit | (dec_idx != last_idx_reg)));

    assign fwd_req   = m_req_i & hit & !stall;
    assign miss_gnt  = m_req_i & !hit & !stall;
    assign accept    = fwd_req & s_gnt_i;
    assign rsp_dec   = s_rvalid_i & (cnt_reg != '0);
    assign cfg_ready = !locked_reg & (cnt_reg == '0) & !err_pend_reg & !m_req_i;
    assign wr_en     = cfg_we_i & cfg_ready & (32'(cfg_idx_i) < NUM_RULES);

    always_comb begin
        cnt_next = cnt_reg;
        case ({accept, rsp_dec})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                rule_valid[i] <= 1'b1;
                {rule_idx[i], rule_start[i], rule_end[i]} <= DEFAULT_RULES[i*RW +: RW];
            end
        end else begin
            for (int i = 0; i < NUM_RULES; i++) begin
                if (wr_en && (cfg_idx_i == IW'(i))) begin
                    rule_valid[i] <= cfg_valid_i;
                    {rule_idx[i], rule_start[i], rule_end[i]} <= cfg_rule_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg       <= '0;
            last_idx_reg  <= '0;
            err_pend_reg  <= 1'b0;
            locked_reg    <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            err_pend_reg <= miss_gnt;
            if (accept) begin
                last_idx_reg <= dec_idx;
            end
            if (cfg_lock_i) begin
                locked_reg <= 1'b1;
            end
            if (s_rvalid_i && (cnt_reg == '0)) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

`ifdef ADDR_DEC_ERR_CNT_EN
    logic [15:0] err_cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_reg <= '0;
        end else if (miss_gnt && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_reg;
`else
    assign err_cnt_o = '0;
`endif

    // Combinational outputs are held low while reset is asserted, not just after the next edge.
    assign s_req_o       = fwd_req & !rst_i;
    assign m_gnt_o       = (accept | miss_gnt) & !rst_i;
    assign s_idx_o       = rst_i ? '0 : dec_idx;
    assign cfg_ready_o   = cfg_ready & !rst_i;
    assign m_rvalid_o    = err_pend_reg;
    assign m_err_o       = err_pend_reg;
    assign cfg_locked_o  = locked_reg;
    assign outstanding_o = cnt_reg;
    assign proto_err_o   = proto_err_reg;

endmodule

// File: tb/tb_cei_addr_decoder_rt.sv
// Bench for cei_addr_decoder_rt: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_cei_addr_decoder_rt;

    localparam int NR   = 6;
    localparam int MAXO = 4;
    localparam int SW   = 3;
    localparam int IW   = 3;
    localparam int CW   = 3;
    localparam int RW   = SW + 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [RW-1:0] cfg_rule = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_lock = 1'b0;
    logic          cfg_ready;
    logic          cfg_locked;
    logic          m_req = 1'b0;
    logic [31:0]   m_addr = '0;
    logic          m_gnt;
    logic          m_rvalid;
    logic          m_err;
    logic          s_req;
    logic [SW-1:0] s_idx;
    logic          s_gnt = 1'b0;
    logic          s_rvalid = 1'b0;
    logic [CW-1:0] outstanding;
    logic          proto_err;
    logic [15:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    cei_addr_decoder_rt dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_rule_i   (cfg_rule),
        .cfg_valid_i  (cfg_valid),
        .cfg_lock_i   (cfg_lock),
        .cfg_ready_o  (cfg_ready),
        .cfg_locked_o (cfg_locked),
        .m_req_i      (m_req),
        .m_addr_i     (m_addr),
        .m_gnt_o      (m_gnt),
        .m_rvalid_o   (m_rvalid),
        .m_err_o      (m_err),
        .s_req_o      (s_req),
        .s_idx_o      (s_idx),
        .s_gnt_i      (s_gnt),
        .s_rvalid_i   (s_rvalid),
        .outstanding_o(outstanding),
        .proto_err_o  (proto_err),
        .err_cnt_o    (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: rule table as plain arrays, in-flight requests as a queue of slave indices.
    logic [SW-1:0] md_idx   [NR];
    logic [31:0]   md_start [NR];
    logic [31:0]   md_end   [NR];
    bit            md_valid [NR];
    int            inflight [$];
    bit            md_errp;
    bit            md_locked;
    bit            md_proto;
    int            md_ecnt;

    bit            e_hit, e_stall, e_sreq, e_gnt, e_missg, e_ready;
    logic [SW-1:0] e_idx;

    logic          smp_gnt, smp_sreq, smp_rvalid, smp_ready;
    logic [SW-1:0] smp_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        md_idx[0] = 3'd3; md_start[0] = 32'hF010_0000; md_end[0] = 32'hF010_8000;
        md_idx[1] = 3'd1; md_start[1] = 32'hF002_0000; md_end[1] = 32'hF003_0000;
        md_idx[2] = 3'd4; md_start[2] = 32'hF000_0000; md_end[2] = 32'hF001_0000;
        md_idx[3] = 3'd2; md_start[3] = 32'h4000_0000; md_end[3] = 32'h8000_0000;
        md_idx[4] = 3'd0; md_start[4] = 32'h0000_0000; md_end[4] = 32'h1000_0000;
        md_idx[5] = 3'd5; md_start[5] = 32'hF010_0000; md_end[5] = 32'hF020_0000;
        for (int i = 0; i < NR; i++) md_valid[i] = 1'b1;
        inflight.delete();
        md_errp   = 1'b0;
        md_locked = 1'b0;
        md_proto  = 1'b0;
        md_ecnt   = 0;
    endtask

    task automatic model_eval(input bit req, input logic [31:0] addr, input bit gnt);
        int n;
        e_hit = 1'b0;
        e_idx = '0;
        for (int i = 0; i < NR; i++) begin
            if (!e_hit && md_valid[i] && md_start[i] <= addr && addr < md_end[i]) begin
                e_hit = 1'b1;
                e_idx = md_idx[i];
            end
        end
        n = inflight.size();
        e_stall = (n == MAXO) || md_errp ||
                  (n > 0 && (!e_hit || int'(e_idx) != inflight[n-1]));
        e_sreq  = req && e_hit && !e_stall;
        e_missg = req && !e_hit && !e_stall;
        e_gnt   = (e_sreq && gnt) || e_missg;
        e_ready = !md_locked && n == 0 && !md_errp && !req;
    endtask

    task automatic model_update(input bit gnt, input bit rv, input bit we, input logic [IW-1:0] widx,
                                input logic [RW-1:0] wrule, input bit wvalid, input bit lock);
        if (rv) begin
            if (inflight.size() == 0) md_proto = 1'b1;
            else void'(inflight.pop_front());
        end
        if (e_sreq && gnt) inflight.push_back(int'(e_idx));
        md_errp = e_missg;
        if (e_missg && md_ecnt < 65535) md_ecnt++;
        if (we && e_ready && int'(widx) < NR) begin
            md_idx[widx]   = wrule[RW-1:64];
            md_start[widx] = wrule[63:32];
            md_end[widx]   = wrule[31:0];
            md_valid[widx] = wvalid;
        end
        if (lock) md_locked = 1'b1;
    endtask

    task automatic cycle(input bit req, input logic [31:0] addr, input bit gnt, input bit rv,
                         input bit we, input logic [IW-1:0] widx, input logic [RW-1:0] wrule,
                         input bit wvalid, input bit lock);
        int exp_ecnt;
        m_req = req; m_addr = addr; s_gnt = gnt; s_rvalid = rv;
        cfg_we = we; cfg_idx = widx; cfg_rule = wrule; cfg_valid = wvalid; cfg_lock = lock;
        #4;
        model_eval(req, addr, gnt);
`ifdef ADDR_DEC_ERR_CNT_EN
        exp_ecnt = md_ecnt;
`else
        exp_ecnt = 0;
`endif
        smp_gnt = m_gnt; smp_sreq = s_req; smp_idx = s_idx; smp_rvalid = m_rvalid; smp_ready = cfg_ready;
        chk("m_gnt",       32'(m_gnt),       32'(e_gnt));
        chk("s_req",       32'(s_req),       32'(e_sreq));
        chk("s_idx",       32'(s_idx),       32'(e_idx));
        chk("m_rvalid",    32'(m_rvalid),    32'(md_errp));
        chk("m_err",       32'(m_err),       32'(md_errp));
        chk("cfg_ready",   32'(cfg_ready),   32'(e_ready));
        chk("cfg_locked",  32'(cfg_locked),  32'(md_locked));
        chk("outstanding", 32'(outstanding), 32'(inflight.size()));
        chk("proto_err",   32'(proto_err),   32'(md_proto));
        chk("err_cnt",     32'(err_cnt),     32'(exp_ecnt));
        @(posedge clk);
        model_update(gnt, rv, we, widx, wrule, wvalid, lock);
        #1;
    endtask

    task automatic req_cycle(input bit req, input logic [31:0] addr, input bit gnt, input bit rv);
        cycle(req, addr, gnt, rv, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_s_req",       32'(s_req),       0);
        chk("rst_m_gnt",       32'(m_gnt),       0);
        chk("rst_s_idx",       32'(s_idx),       0);
        chk("rst_m_rvalid",    32'(m_rvalid),    0);
        chk("rst_m_err",       32'(m_err),       0);
        chk("rst_cfg_ready",   32'(cfg_ready),   0);
        chk("rst_cfg_locked",  32'(cfg_locked),  0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_proto_err",   32'(proto_err),   0);
        chk("rst_err_cnt",     32'(err_cnt),     0);
        m_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b0; cfg_we = 1'b0; cfg_lock = 1'b0; m_addr = '0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        $display("reset applied at %0t", $time);
    endtask

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          gnt;
        bit          rv;
        bit          x_gnt;
        bit          x_sreq;
        int          x_idx;
        bit          x_rvalid;
        int          x_out;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   a;
        logic [31:0]   base;
        logic [RW-1:0] wr;
        bit            r, g, v, w;
        int            k;

        //           req  addr          gnt rv  gnt sreq idx rvalid out
        vecs[0]  = '{1, 32'hF010_7FFC, 1, 0,  1,  1,  3,  0,  0};
        vecs[1]  = '{0, 32'h0000_0000, 0, 0,  0,  0,  0,  0,  1};
        vecs[2]  = '{1, 32'hF010_8000, 1, 1,  0,  0,  5,  0,  1};
        vecs[3]  = '{1, 32'hF010_8000, 1, 0,  1,  1,  5,  0,  0};
        vecs[4]  = '{1, 32'hF01F_FFFF, 0, 0,  0,  1,  5,  0,  1};
        vecs[5]  = '{1, 32'hF01F_FFFF, 1, 1,  1,  1,  5,  0,  1};
        vecs[6]  = '{1, 32'hBADA_0000, 1, 1,  0,  0,  0,  0,  1};
        vecs[7]  = '{1, 32'hBADA_0000, 1, 0,  1,  0,  0,  0,  0};
        vecs[8]  = '{1, 32'h4000_0000, 1, 0,  0,  0,  2,  1,  0};
        vecs[9]  = '{1, 32'h4000_0000, 1, 0,  1,  1,  2,  0,  0};
        vecs[10] = '{0, 32'h7FFF_FFFF, 0, 1,  0,  0,  2,  0,  1};
        vecs[11] = '{1, 32'h8000_0000, 1, 0,  1,  0,  0,  0,  0};
        vecs[12] = '{0, 32'h0000_0000, 0, 0,  0,  0,  0,  1,  0};

        model_reset();
        apply_reset();

        for (int i = 0; i < 13; i++) begin
            chk($sformatf("vec%0d_out", i), 32'(outstanding), 32'(vecs[i].x_out));
            req_cycle(vecs[i].req, vecs[i].addr, vecs[i].gnt, vecs[i].rv);
            chk($sformatf("vec%0d_gnt", i),    32'(smp_gnt),    32'(vecs[i].x_gnt));
            chk($sformatf("vec%0d_sreq", i),   32'(smp_sreq),   32'(vecs[i].x_sreq));
            chk($sformatf("vec%0d_idx", i),    32'(smp_idx),    32'(vecs[i].x_idx));
            chk($sformatf("vec%0d_rvalid", i), 32'(smp_rvalid), 32'(vecs[i].x_rvalid));
            $display("vec %0d addr=%08h gnt=%0b sreq=%0b idx=%0d rvalid=%0b", i, vecs[i].addr,
                     smp_gnt, smp_sreq, smp_idx, smp_rvalid);
        end

        // Slave switch stalls until both earlier responses return, then grants at cnt==0.
        req_cycle(1, 32'hF010_0000, 1, 0);
        req_cycle(1, 32'hF010_0000, 1, 0);
        chk("t3_out2", 32'(outstanding), 2);
        req_cycle(1, 32'hF000_0000, 1, 0);
        chk("t3_stall_a", 32'(smp_gnt), 0);
        req_cycle(1, 32'hF000_0000, 1, 1);
        chk("t3_stall_b", 32'(smp_gnt), 0);
        req_cycle(1, 32'hF000_0000, 1, 1);
        chk("t3_stall_c", 32'(smp_gnt), 0);
        req_cycle(1, 32'hF000_0000, 1, 0);
        chk("t3_grant", 32'(smp_gnt), 1);
        chk("t3_idx", 32'(smp_idx), 4);
        req_cycle(0, 32'h0, 0, 1);
        $display("t3 slave switch sequence done");

        // Outstanding limit.
        for (int i = 0; i < 4; i++) req_cycle(1, 32'hF010_0000, 1, 0);
        chk("t4_full", 32'(outstanding), 4);
        req_cycle(1, 32'hF010_0000, 1, 0);
        chk("t4_stall", 32'(smp_gnt), 0);
        req_cycle(1, 32'hF010_0000, 1, 1);
        chk("t4_stall_rv", 32'(smp_gnt), 0);
        chk("t4_out3", 32'(outstanding), 3);
        req_cycle(1, 32'hF010_0000, 1, 1);
        chk("t4_both_gnt", 32'(smp_gnt), 1);
        chk("t4_both_out", 32'(outstanding), 3);
        req_cycle(1, 32'hF010_0000, 1, 0);
        chk("t4_refill", 32'(outstanding), 4);
        for (int i = 0; i < 4; i++) req_cycle(0, 32'h0, 0, 1);
        chk("t4_drained", 32'(outstanding), 0);
        $display("t4 outstanding limit sequence done");

        // Randomized traffic with occasional (sometimes rejected) table writes.
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, NR - 1);
            case ($urandom_range(0, 5))
                0: a = md_start[k];
                1: a = md_end[k] - 32'd1;
                2: a = md_end[k];
                3: a = md_start[k] - 32'd1;
                4: a = $urandom;
                default: a = md_start[k] + ($urandom_range(0, 255) << 2);
            endcase
            r = ($urandom_range(0, 3) != 0);
            g = ($urandom_range(0, 2) != 0);
            v = (inflight.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
            w = ($urandom_range(0, 9) == 0);
            if (w) r = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: base = 32'hF000_0000;
                1: base = 32'hF010_0000;
                2: base = 32'h4000_0000;
                default: base = 32'h2000_0000;
            endcase
            wr = {3'($urandom_range(0, 5)), base, base + 32'($urandom_range(0, 2) * 32'h0001_0000)};
            cycle(r, a, g, v, w, 3'($urandom_range(0, 7)), wr, ($urandom_range(0, 4) != 0), 1'b0);
            if (smp_gnt) $display("txn %0d addr=%08h hit=%0b idx=%0d", n, a, smp_sreq, smp_idx);
        end

        apply_reset();

        // Reprogram, then lock: a write in the lock cycle lands, later writes are dropped.
        cycle(0, 32'h0, 0, 0, 1, 3'd1, {3'd5, 32'hF003_0000, 32'hF004_0000}, 1, 0);
        chk("t5_ready", 32'(smp_ready), 1);
        req_cycle(1, 32'hF003_0010, 1, 0);
        chk("t5_new_idx", 32'(smp_idx), 5);
        req_cycle(0, 32'h0, 0, 1);
        cycle(0, 32'h0, 0, 0, 1, 3'd6, {3'd2, 32'h0000_0000, 32'hFFFF_FFFF}, 1, 0);
        cycle(0, 32'h0, 0, 0, 1, 3'd2, {3'd1, 32'h9000_0000, 32'hA000_0000}, 1, 1);
        chk("t5_locked", 32'(cfg_locked), 1);
        cycle(0, 32'h0, 0, 0, 1, 3'd1, {3'd2, 32'hF003_0000, 32'hF004_0000}, 1, 0);
        chk("t5_ready_locked", 32'(smp_ready), 0);
        req_cycle(1, 32'hF003_0010, 0, 0);
        chk("t5_kept_idx", 32'(smp_idx), 5);
        req_cycle(1, 32'h9000_0010, 1, 0);
        chk("t5_lockcycle_idx", 32'(smp_idx), 1);
        chk("t5_lockcycle_gnt", 32'(smp_gnt), 1);
        req_cycle(0, 32'h0, 0, 1);
        $display("t5 config and lock sequence done");

        // Protocol error, then asynchronous reset with requests in flight.
        req_cycle(0, 32'h0, 0, 1);
        chk("t6_proto", 32'(proto_err), 1);
        req_cycle(0, 32'h0, 0, 0);
        chk("t6_sticky", 32'(proto_err), 1);
        req_cycle(1, 32'hF010_0000, 1, 0);
        req_cycle(1, 32'hF010_0000, 1, 0);
        chk("t6_out2", 32'(outstanding), 2);
        m_req = 1'b1; m_addr = 32'hF010_0000; s_gnt = 1'b1;
        #2;
        apply_reset();
        req_cycle(0, 32'h0, 0, 1);
        chk("t6_post_rst_proto", 32'(proto_err), 1);
        chk("t6_post_rst_out", 32'(outstanding), 0);
        $display("t6 proto error and reset sequence done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
